// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side driver.
//   - I/O register addresses seen on ioaddr
//   - 16-bit baud divisor lookup (50 MHz clock, clk/(16*baud)-1)
//   - driver state type
package spart_pkg;

    localparam logic [1:0] IOA_BUF  = 2'b00;  // rx/tx buffer
    localparam logic [1:0] IOA_STAT = 2'b01;  // status
    localparam logic [1:0] IOA_DBL  = 2'b10;  // divisor low byte
    localparam logic [1:0] IOA_DBH  = 2'b11;  // divisor high byte

    localparam logic [15:0] DIV_4800  = 16'h028A;
    localparam logic [15:0] DIV_9600  = 16'h0145;
    localparam logic [15:0] DIV_19200 = 16'h00A2;
    localparam logic [15:0] DIV_38400 = 16'h0050;

    typedef enum logic [2:0] {
        StCfgLow,
        StCfgHigh,
        StIdle,
        StReadRx,
        StWriteTx
    } drv_state_t;

    function automatic logic [15:0] divisor_for(input logic [1:0] sel);
        logic [15:0] div;
        unique case (sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control/handshake signals between the driver (master) and spart (slave).
//   iocs   : one-cycle access strobe
//   iorw   : 1=read, 0=write
//   ioaddr : register select
//   rda    : receive-data-available pulse from spart
//   tbr    : transmit buffer ready from spart
// The 8-bit data bus is bidirectional and is carried as a separate inout net.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver_fifo.sv
// Small synchronous FIFO holding received bytes (used with DRIVER_RXFIFO_EN).
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : enqueue (ignored when full unless popping in the same cycle)
//   pop           : dequeue (ignored when empty)
//   rdata         : oldest entry, valid while !empty
//   full, empty   : occupancy flags
// DEPTH must be a power of two >= 2.
module spart_driver_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spart_driver.sv
// Processor-side bus master for spart: programs the baud divisor after reset
// and on every br_cfg change, then echoes each received byte back out.
//   clk, rst : clock, asynchronous active-low reset
//   br_cfg   : baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   bus      : iocs/iorw/ioaddr strobes out, rda/tbr status in
//   databus  : shared data bus, driven only during write accesses
//   cfg_done : divisor programmed for current br_cfg
//   overrun  : sticky, a received byte was lost
// Build option DRIVER_RXFIFO_EN: received bytes queue in an RXQ_DEPTH-entry
// FIFO instead of a single holding register.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned RXQ_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]     databus,
    output logic           cfg_done,
    output logic           overrun
);
    if (RXQ_DEPTH < 2 || (RXQ_DEPTH & (RXQ_DEPTH - 1)) != 0) begin : g_bad_rxq_depth
        $error("RXQ_DEPTH must be a power of two >= 2");
    end

    drv_state_t  state_q, state_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [1:0]  br_cfg_q, br_cfg_d;
    logic        cfg_done_q, cfg_done_d;
    logic        tbr_q;
    logic        rx_pending_q;
    logic        overrun_q;
    logic [15:0] div_sel;

    logic        rx_push, tx_pop, suppress, iocs_out;
    logic        held_avail, rx_room, lost;
    logic [7:0]  held_byte;

    // Buffer accesses are launched on entry to StReadRx/StWriteTx, so those
    // states coincide with the visible bus cycle. A write whose tbr dropped
    // is killed in that cycle without retiring the byte.
    assign rx_push  = (state_q == StReadRx);
    assign tx_pop   = (state_q == StWriteTx) && bus.tbr;
    assign suppress = (state_q == StWriteTx) && !bus.tbr;
    assign iocs_out = iocs_q && !suppress;

    assign bus.iocs   = iocs_out;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;
    assign databus    = (iocs_out && !iorw_q) ? wdata_q : 8'bz;
    assign cfg_done   = cfg_done_q;
    assign overrun    = overrun_q;

`ifdef DRIVER_RXFIFO_EN
    logic       q_full, q_empty;
    logic [7:0] q_head;

    spart_driver_fifo #(
        .DEPTH(RXQ_DEPTH),
        .WIDTH(8)
    ) u_rxq (
        .clk  (clk),
        .rst  (rst),
        .push (rx_push),
        .pop  (tx_pop),
        .wdata(databus),
        .rdata(q_head),
        .full (q_full),
        .empty(q_empty)
    );

    assign held_avail = !q_empty;
    assign held_byte  = q_head;
    assign rx_room    = !q_full;
    // Queue full and a byte already waiting in spart: the new one is lost.
    assign lost       = bus.rda && rx_pending_q && q_full;
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (rx_push) hold_q <= databus;
            hold_valid_q <= (hold_valid_q && !tx_pop) || rx_push;
        end
    end

    assign held_avail = hold_valid_q;
    assign held_byte  = hold_q;
    assign rx_room    = 1'b1;
    assign lost       = rx_push && hold_valid_q;
`endif

    // CfgLow programs the current br_cfg and latches it; CfgHigh reuses the
    // latched value so both divisor bytes always belong to the same setting.
    assign div_sel = divisor_for((state_q == StCfgLow) ? br_cfg : br_cfg_q);

    always_comb begin
        state_d    = state_q;
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = IOA_STAT;
        wdata_d    = wdata_q;
        br_cfg_d   = br_cfg_q;
        cfg_done_d = cfg_done_q;
        unique case (state_q)
            StCfgLow: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = IOA_DBL;
                wdata_d  = div_sel[7:0];
                br_cfg_d = br_cfg;
                state_d  = StCfgHigh;
            end
            StCfgHigh: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = IOA_DBH;
                wdata_d  = div_sel[15:8];
                state_d  = StIdle;
            end
            StIdle: begin
                if (br_cfg != br_cfg_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = StCfgLow;
                end else begin
                    cfg_done_d = 1'b1;
                    if (rx_pending_q && rx_room) begin
                        iocs_d   = 1'b1;
                        ioaddr_d = IOA_BUF;
                        state_d  = StReadRx;
                    end else if (held_avail && tbr_q) begin
                        iocs_d   = 1'b1;
                        iorw_d   = 1'b0;
                        ioaddr_d = IOA_BUF;
                        wdata_d  = held_byte;
                        state_d  = StWriteTx;
                    end
                end
            end
            StReadRx, StWriteTx: state_d = StIdle;
            default:             state_d = StCfgLow;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StCfgLow;
            iocs_q       <= 1'b0;
            iorw_q       <= 1'b1;
            ioaddr_q     <= IOA_STAT;
            wdata_q      <= '0;
            br_cfg_q     <= 2'b00;
            cfg_done_q   <= 1'b0;
            tbr_q        <= 1'b0;
            rx_pending_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            iocs_q       <= iocs_d;
            iorw_q       <= iorw_d;
            ioaddr_q     <= ioaddr_d;
            wdata_q      <= wdata_d;
            br_cfg_q     <= br_cfg_d;
            cfg_done_q   <= cfg_done_d;
            tbr_q        <= bus.tbr;
            // rda is only one cycle wide; a new pulse beats the read's clear.
            rx_pending_q <= bus.rda || (rx_pending_q && !rx_push);
            overrun_q    <= overrun_q || lost;
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       cfg_done, overrun;
    logic [7:0] spart_rx;
    wire  [7:0] databus;

    spart_driver_if bus ();

    spart_driver #(.RXQ_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .bus     (bus),
        .databus (databus),
        .cfg_done(cfg_done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // spart model: drives its rx buffer whenever iorw=1; floating bus reads 0xFF.
    pullup (databus);
    assign databus = bus.iorw ? spart_rx : 8'bz;

    int n_vec  = 0;
    int n_fail = 0;
    int hiz_errs = 0;

    // Driver must release the bus whenever it is not strobing a write.
    always @(negedge clk) begin
        if (rst && !bus.iocs && !bus.iorw && databus !== 8'hFF) hiz_errs++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Step negedges until an access shows up (bounded), then check it.
    task automatic expect_access(input string name, input logic rw, input logic [1:0] addr,
                                 input logic [7:0] data, input int max_wait, output int waited);
        waited = 0;
        for (int k = 1; k <= max_wait; k++) begin
            @(negedge clk);
            if (bus.iocs) begin
                waited = k;
                break;
            end
        end
        if (waited == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no access within %0d cycles", name, max_wait);
        end else begin
            check({name, "_iorw"}, 32'(bus.iorw), 32'(rw));
            check({name, "_addr"}, 32'(bus.ioaddr), 32'(addr));
            check({name, "_data"}, 32'(databus), 32'(data));
        end
    endtask

    task automatic pulse_rda(input logic [7:0] rx);
        spart_rx = rx;
        bus.rda  = 1'b1;
        @(negedge clk);
        bus.rda  = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  cfg;
        logic        reconfig;
        logic [15:0] div;
        logic [7:0]  rx;
    } vec_t;

    vec_t vecs [5];

    initial begin : main
        int w;
        int cnt;
        vecs[0] = '{cfg: 2'b11, reconfig: 1'b1, div: 16'h0050, rx: 8'hA5};
        vecs[1] = '{cfg: 2'b11, reconfig: 1'b0, div: 16'h0050, rx: 8'h5A};
        vecs[2] = '{cfg: 2'b00, reconfig: 1'b1, div: 16'h028A, rx: 8'h0F};
        vecs[3] = '{cfg: 2'b10, reconfig: 1'b1, div: 16'h00A2, rx: 8'h00};
        vecs[4] = '{cfg: 2'b01, reconfig: 1'b1, div: 16'h0145, rx: 8'hC7};

        rst      = 1'b0;
        br_cfg   = 2'b01;
        bus.rda  = 1'b0;
        bus.tbr  = 1'b0;
        spart_rx = 8'h00;
        repeat (2) @(negedge clk);

        check("rst_iocs", 32'(bus.iocs), 32'd0);
        check("rst_iorw", 32'(bus.iorw), 32'd1);
        check("rst_ioaddr", 32'(bus.ioaddr), 32'd1);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Initial configuration: 9600 -> 0x0145
        rst = 1'b1;
        expect_access("init_lo", 1'b0, 2'b10, 8'h45, 3, w);
        check("init_lo_wait", 32'(w), 32'd1);
        expect_access("init_hi", 1'b0, 2'b11, 8'h01, 1, w);
        @(negedge clk);
        check("init_cfg_done", 32'(cfg_done), 32'd1);
        check("init_idle", 32'(bus.iocs), 32'd0);

        // Table: optional reconfiguration followed by an echo with tbr=1
        bus.tbr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].reconfig) begin
                br_cfg = vecs[i].cfg;
                @(negedge clk);
                check($sformatf("v%0d_cfg_drop", i), 32'(cfg_done), 32'd0);
                expect_access($sformatf("v%0d_div_lo", i), 1'b0, 2'b10, vecs[i].div[7:0], 3, w);
                expect_access($sformatf("v%0d_div_hi", i), 1'b0, 2'b11, vecs[i].div[15:8], 1, w);
                @(negedge clk);
                check($sformatf("v%0d_cfg_done", i), 32'(cfg_done), 32'd1);
            end
            pulse_rda(vecs[i].rx);
            expect_access($sformatf("v%0d_rx_rd", i), 1'b1, 2'b00, vecs[i].rx, 1, w);
            expect_access($sformatf("v%0d_tx_wr", i), 1'b0, 2'b00, vecs[i].rx, 3, w);
            check($sformatf("v%0d_tx_wait", i), 32'(w), 32'd2);
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'(bus.iocs), 32'd0);
        end

        // rda during reconfiguration is held and serviced afterwards
        br_cfg = 2'b00;
        pulse_rda(8'h77);
        expect_access("early_div_lo", 1'b0, 2'b10, 8'h8A, 3, w);
        expect_access("early_div_hi", 1'b0, 2'b11, 8'h02, 1, w);
        expect_access("early_rx_rd", 1'b1, 2'b00, 8'h77, 3, w);
        expect_access("early_tx_wr", 1'b0, 2'b00, 8'h77, 3, w);

        // tbr=0: byte held, no write; a tbr blip is suppressed; real rise writes
        @(negedge clk);
        bus.tbr = 1'b0;
        pulse_rda(8'h3C);
        expect_access("hold_rx_rd", 1'b1, 2'b00, 8'h3C, 1, w);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.iocs) cnt++;
        end
        check("hold_no_write", 32'(cnt), 32'd0);
        bus.tbr = 1'b1;
        @(negedge clk);
        bus.tbr = 1'b0;
        @(negedge clk);
        check("blip_iocs", 32'(bus.iocs), 32'd0);
        check("blip_iorw", 32'(bus.iorw), 32'd0);
        check("blip_bus_free", 32'(databus), 32'hFF);
        repeat (2) @(negedge clk);
        bus.tbr = 1'b1;
        expect_access("hold_tx_wr", 1'b0, 2'b00, 8'h3C, 3, w);
        check("hold_tx_wait", 32'(w), 32'd2);

        // Two bytes arrive while tbr=0
        @(negedge clk);
        bus.tbr = 1'b0;
        pulse_rda(8'h11);
        expect_access("ovr_rd1", 1'b1, 2'b00, 8'h11, 1, w);
        pulse_rda(8'h22);
        expect_access("ovr_rd2", 1'b1, 2'b00, 8'h22, 2, w);
        @(negedge clk);
        bus.tbr = 1'b1;
`ifdef DRIVER_RXFIFO_EN
        check("ovr_flag", 32'(overrun), 32'd0);
        expect_access("ovr_tx1", 1'b0, 2'b00, 8'h11, 3, w);
        expect_access("ovr_tx2", 1'b0, 2'b00, 8'h22, 3, w);
`else
        check("ovr_flag", 32'(overrun), 32'd1);
        expect_access("ovr_tx1", 1'b0, 2'b00, 8'h22, 3, w);
`endif
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.iocs) cnt++;
        end
        check("ovr_no_extra", 32'(cnt), 32'd0);

        // Reset asserted in the middle of a tx write
        bus.tbr = 1'b0;
        pulse_rda(8'hC3);
        expect_access("mid_rx_rd", 1'b1, 2'b00, 8'hC3, 1, w);
        @(negedge clk);
        bus.tbr = 1'b1;
        expect_access("mid_tx_wr", 1'b0, 2'b00, 8'hC3, 3, w);
        spart_rx = 8'h5A;
        rst = 1'b0;
        #1;
        check("mid_rst_iocs", 32'(bus.iocs), 32'd0);
        check("mid_rst_iorw", 32'(bus.iorw), 32'd1);
        check("mid_rst_bus", 32'(databus), 32'h5A);
        check("mid_rst_cfg_done", 32'(cfg_done), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_access("post_div_lo", 1'b0, 2'b10, 8'h8A, 3, w);
        expect_access("post_div_hi", 1'b0, 2'b11, 8'h02, 1, w);
        @(negedge clk);
        check("post_cfg_done", 32'(cfg_done), 32'd1);

        check("bus_release", 32'(hiz_errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
